// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 engine: controller state encoding,
// message-expansion state codes and block geometry.
package sha256_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT_ME = 3'd2,
        ST_ROUND   = 3'd3,
        ST_ACCUM   = 3'd4,
        ST_DRAIN   = 3'd5,
        ST_DONE    = 3'd6
    } ctrl_state_t;

    typedef enum logic [1:0] {
        ME_IDLE   = 2'b00,
        ME_LOAD   = 2'b01,
        ME_EXPAND = 2'b10,
        ME_CLEAN  = 2'b11
    } me_state_t;

    localparam int ROUNDS      = 64;
    localparam int BLOCK_WORDS = 16;

    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/sha256_block_ctrl.sv
// Block sequencer for one SHA-256 engine: streams 16 words into the message
// expansion unit, forwards the 64 expanded words to the round unit, and
// brackets each message with hash init / accumulate / digest handshake.
module sha256_block_ctrl
    import sha256_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ME_TIMEOUT = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_last,
    output logic                  me_start,
    output logic [4:0]            me_count,
    output logic [DATA_WIDTH-1:0] me_data,
    input  logic                  me_dv,
    input  logic [DATA_WIDTH-1:0] me_w,
    input  logic [1:0]            me_state,
    output logic                  cmp_init,
    output logic                  cmp_en,
    output logic [5:0]            cmp_round,
    output logic [DATA_WIDTH-1:0] cmp_w,
    output logic                  cmp_accum,
    output logic                  digest_valid,
    input  logic                  digest_ready,
    output logic                  busy,
    output logic                  err,
    output logic [15:0]           block_cnt
);

    localparam int                TMO_W      = $clog2(ME_TIMEOUT + 1);
    localparam logic [3:0]        LAST_WORD  = 4'(BLOCK_WORDS - 1);
    localparam logic [5:0]        LAST_ROUND = 6'(ROUNDS - 1);
    localparam logic [TMO_W-1:0]  TMO_LAST   = TMO_W'(ME_TIMEOUT - 1);

    ctrl_state_t      state_reg, state_next;
    logic [3:0]       word_idx_reg;
    logic [5:0]       round_reg;
    logic [TMO_W-1:0] tmo_reg;
    logic             s_ready_reg;
    logic             last_reg;
    logic             err_reg;
    logic             dv_d_reg;
    logic [15:0]      block_cnt_reg;
    logic             accept;

    // s_ready is only ever set while heading into IDLE or LOAD, so this is the handshake
    assign accept = s_valid && s_ready_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE:    if (accept) state_next = ST_LOAD;
            ST_LOAD:    if (accept && word_idx_reg == LAST_WORD) state_next = ST_WAIT_ME;
            ST_WAIT_ME: begin
                // a data-valid on the final allowed cycle still wins over the timeout
                if (me_dv)                     state_next = ST_ROUND;
                else if (tmo_reg == TMO_LAST)  state_next = ST_IDLE;
            end
            ST_ROUND:   if (dv_d_reg && round_reg == LAST_ROUND) state_next = ST_ACCUM;
            ST_ACCUM:   state_next = ST_DRAIN;
            ST_DRAIN:   if (me_state == ME_IDLE) state_next = last_reg ? ST_DONE : ST_LOAD;
            ST_DONE:    if (digest_ready) state_next = ST_IDLE;
            default:    state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s_ready_reg   <= 1'b0;
            dv_d_reg      <= 1'b0;
            word_idx_reg  <= '0;
            round_reg     <= '0;
            tmo_reg       <= '0;
            last_reg      <= 1'b0;
            err_reg       <= 1'b0;
            block_cnt_reg <= '0;
        end else begin
            s_ready_reg <= (state_next == ST_IDLE) || (state_next == ST_LOAD);
            dv_d_reg    <= me_dv;
            // wraps 15 -> 0, so every block load starts at index 0
            if (accept) begin
                word_idx_reg <= word_idx_reg + 4'd1;
            end
            if (accept && word_idx_reg == LAST_WORD) begin
                last_reg <= s_last;
            end
            tmo_reg <= (state_reg == ST_WAIT_ME) ? tmo_reg + TMO_W'(1) : '0;
            if (state_reg == ST_ROUND && dv_d_reg) begin
                round_reg <= round_reg + 6'd1;
            end
            if (state_reg == ST_WAIT_ME && !me_dv && tmo_reg == TMO_LAST) begin
                err_reg <= 1'b1;
            end
            if (state_reg == ST_IDLE && accept) begin
                block_cnt_reg <= '0;
            end else if (state_reg == ST_ACCUM) begin
                block_cnt_reg <= sat_inc16(block_cnt_reg);
            end
        end
    end

    always_comb begin
        s_ready      = s_ready_reg;
        me_start     = accept;
        me_count     = accept ? {1'b0, word_idx_reg} : 5'd0;
        me_data      = accept ? s_data : '0;
        cmp_init     = (state_reg == ST_IDLE) && accept;
        // expanded word arrives one cycle after its valid, hence the delayed strobe
        cmp_en       = (state_reg == ST_ROUND) && dv_d_reg;
        cmp_round    = (state_reg == ST_ROUND) ? round_reg : 6'd0;
        cmp_w        = cmp_en ? me_w : '0;
        cmp_accum    = (state_reg == ST_ACCUM);
        digest_valid = (state_reg == ST_DONE);
        busy         = (state_reg != ST_IDLE);
        err          = err_reg;
        block_cnt    = block_cnt_reg;
    end

endmodule

// File: tb/tb_sha256_block_ctrl.sv
// Directed/randomized bench for sha256_block_ctrl with a behavioural
// message-expansion model and a plain-arithmetic W[t] reference.
module tb_sha256_block_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [31:0] s_data = '0;
    logic        s_last = 1'b0;
    logic        me_start;
    logic [4:0]  me_count;
    logic [31:0] me_data;
    logic        me_dv = 1'b0;
    logic [31:0] me_w = '0;
    logic [1:0]  me_state = 2'b00;
    logic        cmp_init;
    logic        cmp_en;
    logic [5:0]  cmp_round;
    logic [31:0] cmp_w;
    logic        cmp_accum;
    logic        digest_valid;
    logic        digest_ready = 1'b0;
    logic        busy;
    logic        err;
    logic [15:0] block_cnt;

    sha256_block_ctrl #(.DATA_WIDTH(32), .ME_TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_last(s_last),
        .me_start(me_start), .me_count(me_count), .me_data(me_data),
        .me_dv(me_dv), .me_w(me_w), .me_state(me_state),
        .cmp_init(cmp_init), .cmp_en(cmp_en), .cmp_round(cmp_round), .cmp_w(cmp_w),
        .cmp_accum(cmp_accum), .digest_valid(digest_valid), .digest_ready(digest_ready),
        .busy(busy), .err(err), .block_cnt(block_cnt)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- reference arithmetic ----------------
    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction
    function automatic logic [31:0] ssig0(input logic [31:0] x);
        return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    endfunction
    function automatic logic [31:0] ssig1(input logic [31:0] x);
        return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    endfunction
    function automatic logic [63:0][31:0] w_expand(input logic [15:0][31:0] m);
        logic [63:0][31:0] w;
        for (int t = 0; t < 64; t++) begin
            if (t < 16) w[t] = m[t];
            else        w[t] = ssig1(w[t-2]) + w[t-7] + ssig0(w[t-15]) + w[t-16];
        end
        return w;
    endfunction

    // ---------------- ME model configuration and logs ----------------
    int  me_delay = 2;
    int  gap_at   = -1;
    int  gap_len  = 0;
    bit  me_dead  = 1'b0;
    int  cleanup_len = 8;

    int  plan_q[$];
    int  cleanup_left = 0;
    bit  me_loading = 1'b0;
    bit  me_stuck = 1'b0;
    int  cur_t = -1;
    logic [15:0][31:0] me_words;
    logic [63:0][31:0] me_sched;

    int  init_cnt, accum_cnt, start_cnt, start_busy;
    int  rnd_q[$];
    logic [31:0] w_q[$];
    int  en_cyc_q[$];
    int  dv_cyc_q[$];
    int  cnt_q[$];
    logic [31:0] data_q[$];
    logic [31:0] exp_w_q[$];
    logic [31:0] sent_q[$];

    // Observe at negedge, drive the ME side just after posedge
    initial begin
        forever begin
            @(negedge clk);
            if (rst_n) begin
                if (cmp_init)  init_cnt++;
                if (cmp_accum) accum_cnt++;
                if (cmp_en) begin
                    rnd_q.push_back(int'(cmp_round));
                    w_q.push_back(cmp_w);
                    en_cyc_q.push_back(cyc);
                end
                if (me_dv) dv_cyc_q.push_back(cyc);
                if (me_start) begin
                    start_cnt++;
                    cnt_q.push_back(int'(me_count));
                    data_q.push_back(me_data);
                    if (me_state == 2'b10 || me_state == 2'b11) start_busy++;
                    me_words[me_count[3:0]] = me_data;
                    if (me_count == 5'd15) begin
                        me_loading = 1'b0;
                        if (me_dead) begin
                            me_stuck = 1'b1;
                        end else begin
                            me_sched = w_expand(me_words);
                            for (int k = 0; k < me_delay - 1; k++) plan_q.push_back(-1);
                            for (int t = 0; t < 64; t++) begin
                                if (t == gap_at)
                                    for (int g = 0; g < gap_len; g++) plan_q.push_back(-1);
                                plan_q.push_back(t);
                            end
                        end
                    end else begin
                        me_loading = 1'b1;
                    end
                end
            end
            @(posedge clk);
            #1;
            if (!rst_n) begin
                plan_q.delete();
                cleanup_left = 0;
                me_loading = 1'b0;
                me_stuck = 1'b0;
                cur_t = -1;
                me_dv = 1'b0;
                me_state = 2'b00;
                me_w = '0;
            end else begin
                me_w = (cur_t >= 0) ? me_sched[cur_t] : $urandom;
                cur_t = -1;
                if (plan_q.size() > 0) begin
                    cur_t = plan_q.pop_front();
                    me_dv = (cur_t >= 0);
                    me_state = 2'b10;
                    if (plan_q.size() == 0) cleanup_left = cleanup_len;
                end else if (cleanup_left > 0) begin
                    me_dv = 1'b0;
                    me_state = 2'b11;
                    cleanup_left--;
                end else begin
                    me_dv = 1'b0;
                    me_state = me_stuck ? 2'b10 : (me_loading ? 2'b01 : 2'b00);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    // ---------------- helpers ----------------
    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        total++;
        assert (observed === expected) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, observed, expected);
        end
    endtask

    task automatic clear_logs();
        init_cnt = 0; accum_cnt = 0; start_cnt = 0; start_busy = 0;
        rnd_q.delete(); w_q.delete(); en_cyc_q.delete(); dv_cyc_q.delete();
        cnt_q.delete(); data_q.delete(); exp_w_q.delete(); sent_q.delete();
    endtask

    task automatic send_word(input logic [31:0] d, input logic l, output bit ok);
        bit acc = 1'b0;
        s_valid = 1'b1; s_data = d; s_last = l;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
        end
        s_valid = 1'b0; s_data = $urandom; s_last = 1'b0;
        ok = acc;
    endtask

    // s_last is driven opposite to its block value on words 0..14
    task automatic send_block(input logic [15:0][31:0] m, input int nwords, input bit last, input bit toggle);
        bit ok;
        logic [63:0][31:0] e;
        for (int i = 0; i < nwords; i++) begin
            send_word(m[i], (i == 15) ? last : !last, ok);
            check($sformatf("accept_word%0d", i), ok, 1);
            sent_q.push_back(m[i]);
            if (toggle) begin
                @(posedge clk);
                #1;
            end
        end
        if (nwords == 16) begin
            e = w_expand(m);
            for (int t = 0; t < 64; t++) exp_w_q.push_back(e[t]);
        end
    endtask

    task automatic wait_digest();
        bit seen = 1'b0;
        for (int n = 0; n < 600; n++) begin
            @(negedge clk);
            if (digest_valid) begin
                seen = 1'b1;
                break;
            end
        end
        check("digest_wait", seen, 1);
    endtask

    task automatic ack_digest(input int hold);
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("digest_hold", digest_valid, 1);
        end
        @(posedge clk); #1;
        digest_ready = 1'b1;
        @(posedge clk); #1;
        digest_ready = 1'b0;
        @(negedge clk);
        check("idle_busy", busy, 0);
        check("idle_digest_valid", digest_valid, 0);
        check("idle_s_ready", s_ready, 1);
        @(posedge clk); #1;
    endtask

    task automatic check_rounds(input int nblk);
        check("n_rounds", rnd_q.size(), 64 * nblk);
        check("n_me_start", start_cnt, sent_q.size());
        for (int i = 0; i < rnd_q.size() && i < exp_w_q.size() && i < dv_cyc_q.size(); i++) begin
            check($sformatf("round_idx[%0d]", i), rnd_q[i], i % 64);
            check($sformatf("round_w[%0d]", i), w_q[i], exp_w_q[i]);
            check($sformatf("en_lag[%0d]", i), en_cyc_q[i] - dv_cyc_q[i], 1);
        end
        for (int i = 0; i < cnt_q.size() && i < sent_q.size(); i++) begin
            check($sformatf("me_count[%0d]", i), cnt_q[i], i % 16);
            check($sformatf("me_data[%0d]", i), data_q[i], sent_q[i]);
        end
    endtask

    task automatic check_reset_outputs(input string pfx);
        check({pfx, "_s_ready"}, s_ready, 0);
        check({pfx, "_me_start"}, me_start, 0);
        check({pfx, "_me_count"}, me_count, 0);
        check({pfx, "_me_data"}, me_data, 0);
        check({pfx, "_cmp_init"}, cmp_init, 0);
        check({pfx, "_cmp_en"}, cmp_en, 0);
        check({pfx, "_cmp_round"}, cmp_round, 0);
        check({pfx, "_cmp_w"}, cmp_w, 0);
        check({pfx, "_cmp_accum"}, cmp_accum, 0);
        check({pfx, "_digest_valid"}, digest_valid, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_err"}, err, 0);
        check({pfx, "_block_cnt"}, block_cnt, 0);
    endtask

    // ---------------- directed sequence ----------------
    logic [15:0][31:0] m, m2;

    initial begin
        // reset values, with a word offered during reset
        s_valid = 1'b1; s_data = $urandom;
        repeat (2) @(negedge clk);
        check_reset_outputs("rst");
        s_valid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("post_rst_s_ready", s_ready, 1);
        check("post_rst_busy", busy, 0);
        @(posedge clk); #1;

        // single "abc" block
        clear_logs();
        m = '0;
        m[0] = 32'h61626380;
        m[15] = 32'h00000018;
        send_block(m, 16, 1'b1, 1'b0);
        wait_digest();
        check("abc_init_cnt", init_cnt, 1);
        check("abc_accum_cnt", accum_cnt, 1);
        check("abc_block_cnt", block_cnt, 1);
        check_rounds(1);
        if (w_q.size() > 17) begin
            check("abc_w16", w_q[16], 32'h61626380);
            check("abc_w17", w_q[17], 32'h000F0000);
        end
        ack_digest(3);

        // two-block message, ME answers on the last permitted cycle
        clear_logs();
        me_delay = 4;
        for (int i = 0; i < 16; i++) begin m[i] = $urandom; m2[i] = $urandom; end
        send_block(m, 16, 1'b0, 1'b0);
        send_block(m2, 16, 1'b1, 1'b0);
        wait_digest();
        check("two_init_cnt", init_cnt, 1);
        check("two_accum_cnt", accum_cnt, 2);
        check("two_block_cnt", block_cnt, 2);
        check("two_load_while_me_busy", start_busy, 0);
        check("two_err", err, 0);
        check_rounds(2);
        ack_digest(1);
        me_delay = 2;

        // s_valid every other cycle plus a 3-cycle dv gap before t=20
        clear_logs();
        gap_at = 20; gap_len = 3;
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        send_block(m, 16, 1'b1, 1'b1);
        wait_digest();
        check_rounds(1);
        if (en_cyc_q.size() > 20) begin
            check("gap_before", en_cyc_q[19] - en_cyc_q[18], 1);
            check("gap_span", en_cyc_q[20] - en_cyc_q[19], 4);
        end
        check("gap_block_cnt", block_cnt, 1);
        ack_digest(1);
        gap_at = -1; gap_len = 0;

        // ME never produces data -> timeout
        clear_logs();
        me_dead = 1'b1;
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        send_block(m, 16, 1'b1, 1'b0);
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            check($sformatf("tmo_err_early%0d", k), err, 0);
            check($sformatf("tmo_busy%0d", k), busy, 1);
        end
        @(negedge clk);
        check("tmo_err", err, 1);
        check("tmo_idle_busy", busy, 0);
        check("tmo_s_ready", s_ready, 1);
        repeat (3) @(negedge clk);
        check("tmo_err_sticky", err, 1);
        check("tmo_no_rounds", rnd_q.size(), 0);
        me_dead = 1'b0;
        @(posedge clk); #1;

        // reset clears the sticky error
        rst_n = 1'b0;
        #2;
        check("rst_clears_err", err, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // slow digest consumer, then reset in the middle of a second block load
        clear_logs();
        for (int i = 0; i < 16; i++) m[i] = $urandom;
        send_block(m, 16, 1'b1, 1'b0);
        wait_digest();
        check("slow_block_cnt", block_cnt, 1);
        ack_digest(10);
        clear_logs();
        for (int i = 0; i < 16; i++) begin m[i] = $urandom; m2[i] = $urandom; end
        send_block(m, 16, 1'b0, 1'b0);
        send_block(m2, 7, 1'b1, 1'b0);
        check("mid_block_cnt", block_cnt, 1);
        check("mid_busy", busy, 1);
        check("mid_init_cnt", init_cnt, 1);
        s_valid = 1'b1; s_data = $urandom;
        rst_n = 1'b0;
        #2;
        check_reset_outputs("async");
        s_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rerun_s_ready", s_ready, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
